// File: rtl/mul_pipe_unit.sv
// Two-stage pipelined 32x32 multiply unit for the EXE stage.
// S1 holds 34-bit extended operands feeding the multiplier; S2 holds the selected result word.
// Valid/ready on both sides, synchronous flush, opaque tag carried with each operation.
`timescale 1ns/1ps
module mul_pipe_unit #(
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_src1,
   input  logic [31:0]      in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag
);

   // Stage S1: operand register
   logic             s1_valid;
   logic [33:0]      s1_a;
   logic [33:0]      s1_b;
   logic [1:0]       s1_op;
   logic [TAG_W-1:0] s1_tag;

   // Stage S2: result register
   logic             s2_valid;
   logic [31:0]      s2_result;
   logic [TAG_W-1:0] s2_tag;

   logic             s1_adv;
   logic             s2_adv;

   logic             ext_sign;
   logic [33:0]      ext_a;
   logic [33:0]      ext_b;
   logic [63:0]      mul_a;
   logic [63:0]      mul_b;
   logic [63:0]      prod;
   logic             sel_hi;
   logic [31:0]      sel_result;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Operand extension: only MULH.WU zero-extends; reserved op behaves like MUL.W.
   always_comb begin
      ext_sign = (in_op != 2'b10);
      ext_a    = {{2{ext_sign & in_src1[31]}}, in_src1};
      ext_b    = {{2{ext_sign & in_src2[31]}}, in_src2};
   end

   // Multiplier core and result select. Only product bits 63:0 are ever selected, so the
   // 34x34 signed product is formed modulo 2^64 from sign-extended operands.
   always_comb begin
      mul_a      = {{30{s1_a[33]}}, s1_a};
      mul_b      = {{30{s1_b[33]}}, s1_b};
      prod       = mul_a * mul_b;
      sel_hi     = (s1_op == 2'b01) || (s1_op == 2'b10);
      sel_result = sel_hi ? prod[63:32] : prod[31:0];
   end

   // S1 register: capture accepted operation; flush kills only the valid bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s1_tag   <= '0;
      end else begin
         if (flush) begin
            s1_valid <= 1'b0;
         end else if (s1_adv) begin
            s1_valid <= in_valid;
         end
         if (s1_adv && in_valid) begin
            s1_a   <= ext_a;
            s1_b   <= ext_b;
            s1_op  <= in_op;
            s1_tag <= in_tag;
         end
      end
   end

   // S2 register: capture selected product word; contents hold while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_tag    <= '0;
      end else begin
         if (flush) begin
            s2_valid <= 1'b0;
         end else if (s2_adv) begin
            s2_valid <= s1_valid;
         end
         if (s2_adv && s1_valid) begin
            s2_result <= sel_result;
            s2_tag    <= s1_tag;
         end
      end
   end

   assign out_valid  = s2_valid;
   assign out_result = s2_result;
   assign out_tag    = s2_tag;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Scoreboard bench for mul_pipe_unit: directed scenarios plus randomized traffic,
// expected results from an arithmetic reference model.
`timescale 1ns/1ps
module tb_mul_pipe_unit;

   localparam int unsigned TAG_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_src1;
   logic [31:0]      in_src2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   mul_pipe_unit #(.TAG_W(TAG_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic on the 32-bit operands.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b01:   begin p = sa * sb;                       return p[63:32]; end
         2'b10:   begin p = {32'd0, a} * {32'd0, b};       return p[63:32]; end
         default: begin p = sa * sb;                       return p[31:0];  end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops on output handshake, pushes on input handshake (sampled at negedge).
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got result %h tag %0d, required no output (t=%0t)",
                        out_result, out_tag, $time);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("result", out_result, e.res);
               chk("tag", 32'(out_tag), 32'(e.tag));
            end
         end
         if (flush) sb_q.delete();
         else if (in_valid && in_ready)
            sb_q.push_back('{res: model(in_op, in_src1, in_src2), tag: in_tag});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_src1  = a;
      in_src2  = b;
      in_tag   = tag;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: got in_ready 0 for 50 cycles, required acceptance");
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40; i++) begin
         if (sb_q.size() == 0 && !out_valid) break;
         tick();
      end
      chk("drain_pending", 32'(sb_q.size()), 32'd0);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_src1   = '0;
      in_src2   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      tick();

      // Basic op with latency check
      issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3);
      chk("lat_early_valid", 32'(out_valid), 32'd0);
      tick();
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("basic_result", out_result, 32'hFFFF_FFFE);
      chk("basic_tag", 32'(out_tag), 32'd3);
      wait_drain();

      // High words and reserved op
      issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
      issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
      issue(2'b11, 32'd7, 32'd6, 5'd7);
      wait_drain();

      // Streaming: back-to-back, results on consecutive cycles
      issue(2'b00, 32'd1, 32'd1, 5'd10);
      issue(2'b00, 32'd2, 32'd3, 5'd11);
      issue(2'b01, 32'h0001_0000, 32'h0001_0000, 5'd12);
      issue(2'b00, 32'hFFFF_FFFB, 32'd3, 5'd13);
      chk("stream_valid3", 32'(out_valid), 32'd1);
      tick();
      chk("stream_valid4", 32'(out_valid), 32'd1);
      tick();
      chk("stream_empty", 32'(out_valid), 32'd0);
      wait_drain();

      // Backpressure: capacity two, third accepted as first result leaves
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'd11; in_src2 = 32'd12; in_tag = 5'd20;
      @(negedge clk); chk("bp_ready_a", 32'(in_ready), 32'd1); tick();
      in_src1 = 32'd13; in_src2 = 32'd14; in_tag = 5'd21;
      @(negedge clk); chk("bp_ready_b", 32'(in_ready), 32'd1); tick();
      in_op = 2'b10; in_src1 = 32'hDEAD_BEEF; in_src2 = 32'hCAFE_F00D; in_tag = 5'd22;
      @(negedge clk); chk("bp_full_1", 32'(in_ready), 32'd0); tick();
      @(negedge clk); chk("bp_full_2", 32'(in_ready), 32'd0); tick();
      out_ready = 1'b1;
      @(negedge clk); chk("bp_release", 32'(in_ready), 32'd1); tick();
      in_valid = 1'b0;
      wait_drain();

      // Flush with two in flight and one offered
      out_ready = 1'b0;
      issue(2'b00, 32'd100, 32'd3, 5'd24);
      issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd25);
      in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'd9; in_src2 = 32'd9; in_tag = 5'd26;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (4) tick();
      issue(2'b00, 32'd8, 32'd9, 5'd27);
      wait_drain();

      // Asynchronous reset with two in flight
      out_ready = 1'b0;
      issue(2'b00, 32'h0BAD_F00D, 32'd3, 5'd28);
      issue(2'b00, 32'h7777_7777, 32'd5, 5'd29);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_result", out_result, 32'd0);
      chk("arst_out_tag", 32'(out_tag), 32'd0);
      sb_q.delete();
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      issue(2'b00, 32'd5, 32'd5, 5'd30);
      chk("post_rst_early", 32'(out_valid), 32'd0);
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_result", out_result, 32'h0000_0019);
      wait_drain();

      // Randomized traffic with backpressure and occasional flush
      for (int c = 0; c < 600; c++) begin
         out_ready = ($urandom_range(3) != 0);
         flush     = ($urandom_range(39) == 0);
         in_valid  = ($urandom_range(2) != 0);
         in_op     = 2'($urandom_range(3));
         case ($urandom_range(3))
            0:       in_src1 = 32'h8000_0000;
            1:       in_src1 = 32'hFFFF_FFFF;
            default: in_src1 = $urandom;
         endcase
         case ($urandom_range(3))
            0:       in_src2 = 32'h7FFF_FFFF;
            1:       in_src2 = 32'hFFFF_FFFF;
            default: in_src2 = $urandom;
         endcase
         in_tag = 5'($urandom_range(31));
         tick();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_pipe_unit.md
# mul_pipe_unit

Two-stage pipelined multiply unit sitting in the EXE stage between operand forwarding and the 34×34 signed Booth/Wallace multiplier core `mul`. It accepts 32-bit operands with a LoongArch multiply opcode and extends them to 34-bit signed form. It registers the operands into the core, registers the 68-bit product, and returns the selected 32-bit result with a valid/ready handshake, flush support and an opaque tag.

## Interface
- TAG_W, 5, width of the opaque tag (destination register index) carried alongside each operation
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline kill (exception/branch redirect)
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  2  00 MUL.W (low), 01 MULH.W (signed high), 10 MULH.WU (unsigned high), 11 reserved, treated as 00
- in_src1  in  32  multiplicand
- in_src2  in  32  multiplier
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result this cycle
- out_result  out  32  selected product word
- out_tag  out  TAG_W  tag of the result

## Operation
- Stage S1 (operand register) holds s1_valid, 34-bit a, 34-bit b, op, and tag.
- Extension at capture: signed ops (00, 01, 11) use {x[31],x[31],x}; MULH.WU uses {2'b00,x}.
- S1 outputs drive `mul` directly (mul1=a, mul2=b). The core is purely combinational, 68-bit two's-complement product.
- Stage S2 (product register) holds s2_valid, the 68-bit product (or only the selected 32 bits), and the tag.
- Result select: op 00/11 gives prod[31:0]; op 01/10 gives prod[63:32]. Bits 67:64 are discarded.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational, no dependence on in_valid)
- Handshakes: input fires on in_valid && in_ready. Output fires on out_valid && out_ready.
- On s2_adv, S2 loads S1 contents and s2_valid ← s1_valid. On s1_adv, S1 loads input and s1_valid ← in_valid.
- out_valid = s2_valid. out_result and out_tag are S2 register contents, held stable while out_valid && !out_ready.
- Flush has priority over everything at the same edge: s1_valid ← 0 and s2_valid ← 0. An input offered in the flush cycle is dropped. An output handshake in the flush cycle still counts as consumed.
- Data registers are not cleared by flush, only the valid bits.
- reset clears all valid bits and data registers to 0 immediately, without waiting for a clock edge.

## Timing
- Reset values: out_valid 0, out_result 0, out_tag 0, in_ready 1 (both stages empty).
- Latency: accepted at edge N gives out_valid high after edge N+1 (two clocks, register-to-register).
- Throughput: 1 op/cycle while out_ready stays high.
- Capacity: 2 ops. With out_ready low, the third offered op sees in_ready=0 until the output fires.
- Simultaneous out fire and in accept while full: allowed. S2←S1 and S1←input in the same edge, no bubble.
- Ordering: results emerge strictly in acceptance order, never duplicated or reordered.
- Reset asserted mid-operation: outputs drop to reset values asynchronously. Nothing in flight survives. The first acceptance after deassertion is clean.
- Critical path: S1 registers → `mul` → result select → S2. Nothing combinational passes from in_* to out_*.

## Test plan
- Basic: op 00, src1 0xFFFFFFFF, src2 0x00000002, tag 3 → two cycles later out_valid=1, out_result 0xFFFFFFFE, out_tag 3.
- High words:
  - op 01, 0x80000000×0x80000000 → 0x40000000
  - op 01, 0xFFFFFFFF×0xFFFFFFFF → 0x00000000
  - op 10, 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - op 11, 7×6 → 0x0000002A
- Streaming: 4 back-to-back ops (1×1, 2×3, 0x10000×0x10000 op 01, −5×3 op 00), out_ready=1 → results 1, 6, 0x00000001, 0xFFFFFFF1 on four consecutive cycles, tags in order.
- Backpressure: out_ready=0, offer 3 ops → first two accepted, in_ready=0 on third. Raise out_ready → results drain in order, third accepted the same cycle first result fires.
- Flush: two ops in flight plus one offered, assert flush one cycle → next cycle out_valid=0, in_ready=1, and none of the three ever appear. A following op completes normally.
- Reset: assert reset asynchronously (between edges) with two ops in flight → out_valid/out_result/out_tag are 0 before the next edge. After release, an op 00 5×5 returns 0x19 with latency 2.
